// File: rtl/uart_arb_pkg.sv
// Shared types and sizing for the buart transmit arbiter.
package uart_arb_pkg;
    localparam int N_REQ_MAX  = 8;
    localparam int LOCK_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_e;
endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module uart_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one buart transmitter among N_REQ byte streams.
// Define UART_ARB_LOCK_EN to keep a requester's multi-byte message contiguous.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [15:0] LOCK_TIMEOUT = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     uart_wr,
    output logic [7:0]               uart_tx_data,
    input  logic                     uart_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     active,
    output logic                     locked
);
    localparam int IW = $clog2(N_REQ);

    arb_state_e       state, state_nxt;
    logic [IW-1:0]    ptr;
    logic [N_REQ-1:0] elig, pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             take;
    logic             ptr_hold;

    uart_rr_pick #(.N(N_REQ)) u_pick (
        .req   (elig),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef UART_ARB_LOCK_EN
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  lock_q;

    // While locked only the last granted requester may win.
    always_comb elig = lock_q ? (req_valid & (N_REQ'(1) << grant_id)) : req_valid;
    assign ptr_hold = !req_last[pick_idx];
    assign locked   = lock_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q   <= 1'b0;
            lock_cnt <= '0;
        end else if (take) begin
            lock_q   <= !req_last[pick_idx];
            lock_cnt <= '0;
        end else if (lock_q && state == ST_IDLE && !req_valid[grant_id]) begin
            if (lock_cnt + 16'd1 == LOCK_TIMEOUT) begin
                lock_q   <= 1'b0;
                lock_cnt <= '0;
            end else begin
                lock_cnt <= lock_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^{req_last, LOCK_TIMEOUT};
    assign elig     = req_valid;
    assign ptr_hold = 1'b0;
    assign locked   = 1'b0;
`endif

    assign take = (state == ST_IDLE) && !uart_busy && pick_any;

    always_comb begin
        req_ready = '0;
        if (take) req_ready = pick_grant;
    end

    // SETTLE covers the cycle before buart raises busy after a write.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (take) state_nxt = ST_SEND;
            ST_SEND:   state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!uart_busy) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            uart_tx_data <= 8'h00;
            grant_id     <= '0;
            ptr          <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                uart_tx_data <= req_data[{pick_idx, 3'b000} +: 8];
                grant_id     <= pick_idx;
                if (!ptr_hold)
                    ptr <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    assign uart_wr = (state == ST_SEND);
    assign active  = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural buart busy model.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int FRAME = 12;
    localparam int DUMMY = 30;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           uart_wr, uart_busy, active, locked;
    logic [7:0]     uart_tx_data;
    logic [1:0]     grant_id;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(16'd16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_wr(uart_wr),
        .uart_tx_data(uart_tx_data), .uart_busy(uart_busy), .grant_id(grant_id),
        .active(active), .locked(locked)
    );

    always #5 clk = ~clk;

    // buart busy: raised the cycle after wr, never cleared by the arbiter's reset.
    int   busy_cnt = 0;
    logic kick = 1'b0;
    always @(posedge clk) begin
        if (kick)          busy_cnt <= DUMMY;
        else if (uart_wr)  busy_cnt <= FRAME;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_busy = (busy_cnt != 0);

    int         n_tests = 0, n_fail = 0, viol = 0;
    logic [8:0] qm [N][8];
    int         qn [N], qh [N];
    logic [7:0] wlog [16];
    int         nw;
    logic       pend_acc = 1'b0;
    logic [7:0] pend_byte;
    logic [N-1:0] acc;
    logic       s_active, s_locked;
    logic [N-1:0] s_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (qh[k] < qn[k]) begin
                req_valid[k]        = 1'b1;
                req_data[k*8 +: 8]  = qm[k][qh[k]][7:0];
                req_last[k]         = qm[k][qh[k]][8];
            end else begin
                req_valid[k]        = 1'b0;
                req_data[k*8 +: 8]  = 8'h00;
                req_last[k]         = 1'b0;
            end
        end
    endtask

    task automatic push(input int k, input logic [7:0] b, input logic l);
        qm[k][qn[k]] = {l, b};
        qn[k]++;
        drive();
    endtask

    // Sample at negedge, let the edge happen, then update requesters.
    task automatic cyc();
        @(negedge clk);
        if (uart_wr && nw < 16) begin wlog[nw] = uart_tx_data; nw++; end
        if (pend_acc) begin
            if (!uart_wr || uart_tx_data != pend_byte) viol++;
        end else if (uart_wr) viol++;
        if (req_ready != 0 && (active || uart_busy)) viol++;
        if ((req_ready & (req_ready - 1'b1)) != 0) viol++;
        if (uart_wr && uart_busy) viol++;
        s_active = active; s_locked = locked; s_ready = req_ready;
        acc      = req_valid & req_ready;
        pend_acc = (acc != 0);
        for (int k = 0; k < N; k++) if (acc[k]) pend_byte = req_data[k*8 +: 8];
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) if (acc[k]) qh[k]++;
        drive();
    endtask

    task automatic reset_dut(input logic dummy);
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin qn[k] = 0; qh[k] = 0; end
        drive();
        kick = dummy;
        cyc();
        kick = 1'b0;
        cyc();
        reset = 1'b0;
        nw = 0;
    endtask

    function automatic logic queues_busy();
        for (int k = 0; k < N; k++) if (qh[k] < qn[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run(input string tag);
        int n;
        n = 0;
        while ((queues_busy() || active || uart_busy || pend_acc) && n < 600) begin
            cyc(); n++;
        end
        chk(tag, 32'(n < 600), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr"},     32'(uart_wr), 0);
        chk({tag, "_data"},   32'(uart_tx_data), 0);
        chk({tag, "_ready"},  32'(req_ready), 0);
        chk({tag, "_grant"},  32'(grant_id), 0);
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
    endtask

    logic [7:0] exp4 [4];

    initial begin
        int n, idle;
        logic last_locked;
        nw = 0;
        for (int k = 0; k < N; k++) begin qn[k] = 0; qh[k] = 0; end
        drive();

        // reset state
        reset_dut(1'b0);
        chk_reset_vals("rst");

        // post-reset gating by the dummy frame, then a single byte
        reset_dut(1'b1);
        push(1, 8'h55, 1'b1);
        n = 0;
        while (!pend_acc && n < 200) begin cyc(); if (!pend_acc) n++; end
        chk("gate_wait", 32'(n), DUMMY - 1);
        chk("gate_who", 32'(acc), 32'h2);
        run("gate_done");
        chk("single_cnt", 32'(nw), 1);
        chk("single_byte", 32'(wlog[0]), 32'h55);
        chk("single_gid", 32'(grant_id), 1);
        chk("inv_single", 32'(viol), 0);

        // simultaneous requests, rotating order
        reset_dut(1'b0);
        for (int k = 0; k < N; k++) push(k, 8'(8'h41 + k), 1'b1);
        run("simul_done");
        chk("simul_cnt", 32'(nw), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("simul_b%0d", k), 32'(wlog[k]), 32'(8'h41 + k));
        push(2, 8'h43, 1'b1);
        cyc();
        push(0, 8'h41, 1'b1);
        run("rr2_done");
        chk("rr2_first", 32'(wlog[4]), 32'h43);
        chk("rr2_second", 32'(wlog[5]), 32'h41);
        chk("inv_simul", 32'(viol), 0);

        // lock keeps requester 1's message contiguous
        reset_dut(1'b0);
        push(1, "a", 1'b0); push(1, "b", 1'b0); push(1, "c", 1'b1);
        push(2, "z", 1'b1);
`ifdef UART_ARB_LOCK_EN
        exp4[0] = "a"; exp4[1] = "b"; exp4[2] = "c"; exp4[3] = "z";
`else
        exp4[0] = "a"; exp4[1] = "z"; exp4[2] = "b"; exp4[3] = "c";
`endif
        run("lock_done");
        chk("lock_cnt", 32'(nw), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("lock_b%0d", k), 32'(wlog[k]), 32'(exp4[k]));
        chk("lock_clear", 32'(locked), 0);

`ifdef UART_ARB_LOCK_EN
        // lock timeout after 16 idle cycles
        reset_dut(1'b0);
        push(1, "a", 1'b0);
        push(2, "z", 1'b1);
        n = 0;
        while (!pend_acc && n < 50) begin cyc(); n++; end
        chk("to_first", 32'(acc), 32'h2);
        n = 0;
        while (!s_active && n < 50) begin cyc(); n++; end
        while (s_active && n < 100) begin cyc(); n++; end
        idle = 0;
        last_locked = 1'b0;
        while (s_ready == 0 && idle < 100) begin
            idle++; last_locked = s_locked; cyc();
        end
        chk("to_idle", 32'(idle), 16);
        chk("to_lock_before", 32'(last_locked), 1);
        chk("to_lock_after", 32'(s_locked), 0);
        chk("to_grant", 32'(s_ready), 32'h4);
        run("to_done");
`endif

        // reset in DRAIN; frame in flight must finish before the next write
        reset_dut(1'b0);
        push(0, 8'h99, 1'b1);
        n = 0;
        while (!pend_acc && n < 50) begin cyc(); n++; end
        repeat (6) cyc();
        chk("drain_state", 32'({active, uart_busy}), 32'h3);
        push(3, 8'h77, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_reset_vals("drst");
        run("drst_done");
        chk("drst_cnt", 32'(nw), 2);
        chk("drst_b0", 32'(wlog[0]), 32'h99);
        chk("drst_b1", 32'(wlog[1]), 32'h77);
        chk("inv_all", 32'(viol), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `buart` transmitter between up to eight byte-stream requesters, e.g. the Forth console, a debug monitor and a status reporter. It sits between the requesters and the `wr`/`tx_data`/`busy` side of `buart`. It sequences each byte as a one-cycle write strobe and then waits out the UART frame. An optional line lock keeps one requester's multi-byte message contiguous on the wire.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `LOCK_TIMEOUT`, default 65535: idle cycles after which a held lock is dropped. 16-bit. Used only with the lock feature.
- `clk` in 1: system clock, the same clock as `buart`.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: requester k has a byte.
- `req_data` in 8*N_REQ: byte of requester k, at bits [8k+7:8k].
- `req_last` in N_REQ: the byte ends the requester's message. Ignored unless the lock feature is compiled in.
- `req_ready` out N_REQ: one-hot acceptance strobe.
- `uart_wr` out 1: goes to `buart.wr`.
- `uart_tx_data` out 8: goes to `buart.tx_data`.
- `uart_busy` in 1: from `buart.busy`.
- `grant_id` out clog2(N_REQ): last granted requester.
- `active` out 1: state is not IDLE.
- `locked` out 1: a lock is held. Constant 0 without the lock feature.

## Operation
- **Handshake**
  - A transfer happens when `req_valid[k] && req_ready[k]`.
  - A requester holds `req_data` and `req_last` stable while `req_valid` is high.
  - `req_valid` may drop without a transfer.
- **State machine**
  - IDLE:
    - `req_ready` asserts combinationally to the winner when `!uart_busy` and any eligible `req_valid` is high.
    - On that transfer: latch the byte into `uart_tx_data`, set `grant_id` to the winner, set the pointer to winner+1 mod N_REQ, go to SEND.
  - SEND: `uart_wr`=1 for exactly one cycle, go to SETTLE.
  - SETTLE: one cycle with `uart_busy` ignored, because `buart` raises `busy` one cycle after `wr`. Go to DRAIN.
  - DRAIN: stay until `uart_busy`=0, then go to IDLE.
- **Priority**
  - Scan starts at the pointer and wraps modulo N_REQ.
  - The pointer resets to 0.
  - Simultaneous valids are served in rotating order, so no requester waits more than N_REQ-1 bytes.
- **Busy gating**
  - Nothing is granted while `uart_busy` is high in IDLE.
  - This covers the `buart` post-reset dummy frame and a frame still running after this block was reset.
- **Reset**
  - Applies in any state, including mid-frame.
  - Reset values: state IDLE, `uart_wr` 0, `uart_tx_data` 0x00, `req_ready` 0, `grant_id` 0, `active` 0, `locked` 0, pointer 0, timeout counter 0.
  - A `buart` frame already in flight is not aborted.

## Timing
- Acceptance cycle T: `req_ready` high.
- T+1: `uart_wr` high, `uart_tx_data` valid. `uart_tx_data` stays stable until the next acceptance.
- T+2: SETTLE.
- T+3 onward: DRAIN, until `busy` falls.
- Minimum acceptance spacing is the UART frame length plus 3 cycles.
- `req_ready` is never high outside IDLE and is never high for more than one requester.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - Accepting a byte with `req_last`=0 sets `locked` and makes only that requester eligible.
  - Accepting a byte with `req_last`=1 clears the lock.
  - The pointer is not advanced while locked.
  - While locked in IDLE with the owner's `req_valid` low, a counter increments each cycle. It resets on each owner transfer.
  - When the counter reaches `LOCK_TIMEOUT`, the lock drops and normal round-robin resumes next cycle.
- `UART_ARB_LOCK_EN` undefined:
  - `req_last` is ignored, `locked` is tied to 0, and no counter is built.
  - Every byte is arbitrated independently.

## Structure
- Package `uart_arb_pkg`:
  - state encoding `ST_IDLE`, `ST_SEND`, `ST_SETTLE`, `ST_DRAIN`
  - `N_REQ_MAX` = 8
  - lock counter width 16
- Sub-module `uart_rr_pick`: combinational rotating-priority picker.
  - Inputs: request mask, pointer.
  - Outputs: one-hot grant, index, any.

## Test plan
- Single byte with real `buart` (divider 217) after its dummy frame clears:
  - Stimulus: `req_valid[0]`=1, `req_data`=0x55.
  - Required: `req_ready[0]` for 1 cycle, `uart_wr` at T+1 with 0x55, `tx` shows start 0, bits 1,0,1,0,1,0,1,0, stop 1.
- Simultaneous requests:
  - Stimulus: requesters 0..3 all valid with 0x41..0x44.
  - Required: bytes on the wire in order 0x41, 0x42, 0x43, 0x44.
  - Then: re-assert 2 and 0 → order 0x43 (requester 2) then 0x41 (requester 0).
- Post-reset gating:
  - Stimulus: `req_valid[1]` high from the cycle reset deasserts.
  - Required: no `req_ready` until `buart.busy` falls after the 15-bit dummy frame.
- Lock with `UART_ARB_LOCK_EN`, LOCK_TIMEOUT=16:
  - Stimulus: requester 1 sends 'a', 'b' (last=0) then 'c' (last=1), with requester 2 valid 'z' throughout.
  - Required: wire shows "abcz".
  - Without the macro: wire shows "azbc".
- Lock timeout:
  - Stimulus: requester 1 sends 'a' (last=0) then drops valid; requester 2 valid.
  - Required: requester 2 granted exactly 16 idle cycles after DRAIN ends; `locked` falls at the same point.
- Reset in DRAIN:
  - Stimulus: assert `reset` for 1 cycle mid-frame.
  - Required: all outputs at reset values next cycle; no `uart_wr` until `uart_busy`=0; the frame on `tx` completes intact.
